usb_tx_line_encoder: RTL and testbench

Parametrised USB full-speed transmit line encoder. It consumes a serial bit stream through a valid/ready handshake and applies NRZI encoding and bit stuffing. It generates the EOP sequence itself (SE0 for N bits, then J for M bits) and drives dplus/dminus. Bit timing comes from an internal bit-period counter rather than an external rollover strobe. It sits between the TX shift register and the USB pads.

---
 rtl/usb_tx_pkg.sv | 24 ++
 rtl/usb_bit_timer.sv | 33 +++
 rtl/usb_tx_line_encoder.sv | 147 ++++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types for the USB full-speed transmit line encoder: FSM states and
// the two-bit {dplus, dminus} line symbol.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } tx_state_e;

    // Line symbol packed as {dplus, dminus}
    typedef logic [1:0] line_t;

    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    // NRZI transition between the two differential data states
    function automatic line_t line_toggle(input line_t l);
        return (l == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Wrap counter with synchronous clear and enable; strobes wrap_o in the
// enabled cycle where the count equals last_i, then restarts from zero.
module usb_bit_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;

    assign wrap_o = en_i && (count_q == last_i);

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (en_i)
            count_d = wrap_o ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full-speed TX line encoder: NRZI with bit stuffing, self-timed bit
// periods and locally generated EOP, driving registered dplus/dminus.
module usb_tx_line_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int EOP_J_BITS   = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_valid,
    input  logic tx_bit,
    input  logic tx_eop,
    output logic tx_ready,
    output logic dplus,
    output logic dminus,
    output logic tx_active,
    output logic eop_done,
    output logic underrun
);

    localparam int BIT_W   = $clog2(CLKS_PER_BIT);
    localparam int ONES_W  = $clog2(STUFF_LEN + 1);
    localparam int EOP_MAX = (EOP_SE0_BITS > EOP_J_BITS) ? EOP_SE0_BITS : EOP_J_BITS;
    localparam int EOP_W   = (EOP_MAX > 1) ? $clog2(EOP_MAX) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [EOP_W-1:0]  SE0_LAST  = EOP_W'(EOP_SE0_BITS - 1);
    localparam logic [EOP_W-1:0]  J_LAST    = EOP_W'(EOP_J_BITS - 1);

    tx_state_e          state_q, state_d;
    line_t              line_q, line_d;
    logic [ONES_W-1:0]  ones_q, ones_d;

    logic bit_bnd;
    logic eop_last;
    logic in_eop;
    logic stuff_pend;

    assign in_eop     = (state_q == EOP_SE0) || (state_q == EOP_J);
    assign stuff_pend = (ones_q == STUFF_MAX);

    // Bit-period timer: parked at zero in IDLE so DATA starts a fresh period
    usb_bit_timer #(.W(BIT_W)) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (state_q == IDLE),
        .en_i    (state_q != IDLE),
        .last_i  (BIT_LAST),
        .wrap_o  (bit_bnd)
    );

    // EOP timer counts bit periods; its wrap at the last SE0 period leaves it
    // at zero for the J phase without an explicit reload.
    usb_bit_timer #(.W(EOP_W)) u_eop_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (!in_eop),
        .en_i    (in_eop && bit_bnd),
        .last_i  ((state_q == EOP_SE0) ? SE0_LAST : J_LAST),
        .wrap_o  (eop_last)
    );

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        ones_d   = ones_q;
        tx_ready = 1'b0;
        underrun = 1'b0;
        eop_done = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                line_d   = LINE_J;
                ones_d   = '0;
                if (tx_valid) begin
                    state_d = DATA;
                    line_d  = tx_bit ? LINE_J : LINE_K;
                    ones_d  = tx_bit ? ONES_W'(1) : '0;
                end
            end
            DATA: begin
                if (bit_bnd) begin
                    if (stuff_pend) begin
                        line_d = line_toggle(line_q);
                        ones_d = '0;
                    end else if (tx_eop) begin
                        state_d = EOP_SE0;
                        line_d  = LINE_SE0;
                        ones_d  = '0;
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            line_d = tx_bit ? line_q : line_toggle(line_q);
                            ones_d = tx_bit ? ones_q + ONES_W'(1) : '0;
                        end else begin
                            // Starved mid-packet: abort with a normal EOP
                            underrun = 1'b1;
                            state_d  = EOP_SE0;
                            line_d   = LINE_SE0;
                            ones_d   = '0;
                        end
                    end
                end
            end
            EOP_SE0: begin
                line_d = LINE_SE0;
                if (eop_last) begin
                    state_d = EOP_J;
                    line_d  = LINE_J;
                end
            end
            EOP_J: begin
                line_d = LINE_J;
                if (eop_last) begin
                    state_d  = IDLE;
                    eop_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = LINE_J;
                ones_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            line_q  <= LINE_J;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            ones_q  <= ones_d;
        end
    end

    assign dplus     = line_q[1];
    assign dminus    = line_q[0];
    assign tx_active = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Bench for usb_tx_line_encoder: two parameterisations, directed and random
// packets compared cycle by cycle against a per-bit-period symbol timeline.
module tb_usb_tx_line_encoder;

    logic clk = 1'b0;
    logic [1:0] n_rst_v, valid_v, bit_v, eop_v;
    logic [1:0] ready_v, dp_v, dm_v, act_v, done_v, und_v;

    int checks = 0;
    int errors = 0;

    int sel, cpb, stl, se0n, jn;
    logic       pkt[$];
    logic [1:0] sym[$];
    bit         isd[$];

    always #5 clk = ~clk;

    usb_tx_line_encoder u_dut_a (
        .clk(clk), .n_rst(n_rst_v[0]), .tx_valid(valid_v[0]), .tx_bit(bit_v[0]),
        .tx_eop(eop_v[0]), .tx_ready(ready_v[0]), .dplus(dp_v[0]), .dminus(dm_v[0]),
        .tx_active(act_v[0]), .eop_done(done_v[0]), .underrun(und_v[0])
    );

    usb_tx_line_encoder #(
        .CLKS_PER_BIT(4), .STUFF_LEN(3), .EOP_SE0_BITS(3), .EOP_J_BITS(1)
    ) u_dut_b (
        .clk(clk), .n_rst(n_rst_v[1]), .tx_valid(valid_v[1]), .tx_bit(bit_v[1]),
        .tx_eop(eop_v[1]), .tx_ready(ready_v[1]), .dplus(dp_v[1]), .dminus(dm_v[1]),
        .tx_active(act_v[1]), .eop_done(done_v[1]), .underrun(und_v[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_inst(input int s);
        sel = s;
        if (s == 0) begin cpb = 8; stl = 6; se0n = 2; jn = 1; end
        else        begin cpb = 4; stl = 3; se0n = 3; jn = 1; end
    endtask

    task automatic drive(input bit v, input bit b, input bit e);
        valid_v = '0; bit_v = '0; eop_v = '0;
        valid_v[sel] = v; bit_v[sel] = b; eop_v[sel] = e;
    endtask

    function automatic logic [1:0] tog(input logic [1:0] l);
        return (l == 2'b10) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] obs_line();
        return {dp_v[sel], dm_v[sel]};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            @(negedge clk);
            chk("idle_line", obs_line(), 2'b10);
            chk("idle_ready", ready_v[sel], 1);
            chk("idle_active", act_v[sel], 0);
            @(posedge clk); #1;
        end
    endtask

    // Builds the expected symbol of every bit period, then walks the packet
    // cycle by cycle. Entered and left one step after a rising edge, in IDLE.
    task automatic run_pkt(input bit umode);
        logic [1:0] ln;
        int ones, nd, nl, k, b, er;
        bit xfer;
        ln = 2'b10; ones = 0;
        sym.delete(); isd.delete();
        foreach (pkt[i]) begin
            if (ones == stl) begin
                ln = tog(ln); sym.push_back(ln); isd.push_back(1'b0); ones = 0;
            end
            if (pkt[i] == 1'b0) begin ln = tog(ln); ones = 0; end
            else ones++;
            sym.push_back(ln); isd.push_back(1'b1);
        end
        if (ones == stl) begin
            ln = tog(ln); sym.push_back(ln); isd.push_back(1'b0);
        end
        nd = sym.size();
        for (int i = 0; i < se0n; i++) begin sym.push_back(2'b00); isd.push_back(1'b0); end
        for (int i = 0; i < jn; i++)   begin sym.push_back(2'b10); isd.push_back(1'b0); end
        nl = sym.size();

        k = 0;
        for (int c = 0; c <= nl * cpb; c++) begin
            if (k < pkt.size())
                drive(1'b1, pkt[k], (c == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            else if (c > nd * cpb)
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                drive(umode ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), !umode);
            @(negedge clk);
            b = c / cpb;
            if (c == 0) er = 1;
            else if ((c % cpb) == 0 && b <= nd) er = (b < nd) ? int'(isd[b]) : int'(umode);
            else er = 0;
            chk($sformatf("line c%0d", c), obs_line(),
                (c >= 1 && c <= nl * cpb) ? sym[(c - 1) / cpb] : 2'b10);
            chk($sformatf("ready c%0d", c), ready_v[sel], er);
            chk($sformatf("active c%0d", c), act_v[sel], (c >= 1 && c <= nl * cpb) ? 1 : 0);
            chk($sformatf("eop_done c%0d", c), done_v[sel], (c == nl * cpb) ? 1 : 0);
            chk($sformatf("underrun c%0d", c), und_v[sel], (umode && c == nd * cpb) ? 1 : 0);
            xfer = valid_v[sel] && ready_v[sel];
            @(posedge clk); #1;
            if (xfer) k++;
        end
        chk("bits_consumed", k, pkt.size());
    endtask

    initial begin
        bit found;
        int s, len;
        n_rst_v = 2'b00; valid_v = '0; bit_v = '0; eop_v = '0;
        set_inst(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_line", {dp_v[i], dm_v[i]}, 2'b10);
            chk("rst_ready", ready_v[i], 1);
            chk("rst_active", act_v[i], 0);
            chk("rst_eop_done", done_v[i], 0);
            chk("rst_underrun", und_v[i], 0);
        end
        n_rst_v = 2'b11;
        @(posedge clk); #1;

        pkt = {1'b0, 1'b1, 1'b0};
        run_pkt(1'b0);
        idle(2);
        pkt = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_pkt(1'b0);
        pkt = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_pkt(1'b0);
        idle(1);
        pkt = {1'b1, 1'b0, 1'b1, 1'b1};
        run_pkt(1'b1);
        idle(1);

        set_inst(1);
        pkt = {1'b1, 1'b1, 1'b1, 1'b1};
        run_pkt(1'b0);
        idle(1);

        // Reset while the line is in SE0 must return to J at once, no EOP
        drive(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (obs_line() == 2'b00) found = 1'b1;
        end
        chk("se0_reached", found, 1);
        n_rst_v[1] = 1'b0;
        #1;
        chk("rst_mid_line", obs_line(), 2'b10);
        chk("rst_mid_active", act_v[1], 0);
        chk("rst_mid_eop_done", done_v[1], 0);
        @(negedge clk);
        n_rst_v[1] = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        pkt = {1'b0, 1'b1};
        run_pkt(1'b0);

        for (int n = 0; n < 30; n++) begin
            s = int'($urandom_range(0, 1));
            set_inst(s);
            len = int'($urandom_range(1, 16));
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            run_pkt(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
